cache_mem_responder: RTL and testbench
======================================

Name: cache_mem_responder

Overview:
Memory-side responder for the set-associative cache controller. It services the controller's word read/write requests (line fills on miss, write-through on store) against a local word-addressed RAM. Each request receives one response after a fixed, parameterised latency. The block sits between the cache controller and the main-memory model and replaces direct array indexing with a timed valid/ready protocol.

Parameters:
DATA_W, 32, data word width
DEPTH_LOG2, 13, log2 of RAM depth in words (default 8192 words = 32 KiB)
READ_LAT, 4, cycles from read acceptance to rsp_valid; legal range 1..15
WRITE_LAT, 2, cycles from write acceptance to rsp_valid; legal range 1..15

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_op  in  1  0 = read, 1 = write (same encoding as the controller's op)
req_addr  in  32  byte address
req_wdata  in  DATA_W  write data, ignored for reads
rsp_valid  out  1  response present
rsp_ready  in  1  controller accepts the response
rsp_op  out  1  echo of the accepted req_op
rsp_data  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  request was out of range or misaligned

Behaviour:
- Reset (rst_n low, async): state IDLE, req_ready=1, rsp_valid=0, rsp_op=0, rsp_data=0, rsp_err=0, latency counter=0. RAM contents are not cleared and are undefined until written.
- Reset mid-operation: the in-flight request is dropped silently and no RAM write occurs if it had not yet completed. A response is never produced for it.
- FSM states: IDLE, BUSY, RESP. One request outstanding at most.
- IDLE: req_ready=1. On an edge with req_valid=1: latch op, addr, wdata; load cnt = (op ? WRITE_LAT : READ_LAT) - 1; go to BUSY. req_ready drops after that edge.
- BUSY: req_ready=0. If cnt==0, perform the access and go to RESP. Otherwise decrement cnt.
- Latency: rsp_valid rises immediately after the Nth rising edge following the acceptance edge, where N = READ_LAT or WRITE_LAT.
- Access (on the BUSY->RESP edge):
  - Word index = addr[DEPTH_LOG2+1:2].
  - Read: rsp_data = RAM[index].
  - Write: RAM[index] = wdata and rsp_data = 0.
- Error: rsp_err=1 if addr[1:0]!=0 or addr[31:DEPTH_LOG2+2]!=0. On error there is no RAM access and rsp_data=0; latency is unchanged.
- RESP: rsp_valid=1 and rsp_op/rsp_data/rsp_err are held stable until rsp_ready=1 at an edge. On that edge go to IDLE with rsp_valid=0 and rsp_data/rsp_err cleared. req_ready=1 on the following cycle, so the minimum spacing between two requests is N+2 cycles.
- In RESP with rsp_ready=0, back-pressure is held indefinitely. req_valid is ignored (req_ready=0).
- Ordering: a write completes at its BUSY->RESP edge, so any later read returns the written value (read-after-write coherent).
- req_valid asserted in BUSY or RESP is not accepted. The requester must hold the request until it sees req_ready.

Test Plan:
- Write then read, READ_LAT=4, WRITE_LAT=2: write addr=64 data=111 -> rsp_valid rises 2 edges after acceptance, rsp_op=1, rsp_data=0, rsp_err=0. Then read addr=64 -> rsp_valid 4 edges after acceptance, rsp_data=111.
- Aliasing index check: write 222 to addr=1088 and 5000 to addr=2112, then read both -> 222 and 5000 respectively. Read addr=64 -> still 111.
- Back-pressure: read addr=2112 with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data=5000 stable for all 5 cycles, req_ready=0 throughout. Raise rsp_ready -> rsp_valid=0 next cycle and req_ready=1.
- Errors:
  - Read addr=66 (misaligned) -> rsp_err=1, rsp_data=0.
  - Write addr=32768 (out of range, DEPTH_LOG2=13) with data 7 -> rsp_err=1, and a later read of addr=0 does not return 7.
- Reset mid-op: accept a write addr=128 data=9, pull rst_n low 1 cycle later (inside BUSY) -> outputs go to reset values immediately and no response appears. Write 3 to addr=128, then read addr=128 -> 3.
- Latency corner: READ_LAT=1 -> rsp_valid rises after the first edge following acceptance. Back-to-back requests with rsp_ready tied high -> acceptances exactly N+2 cycles apart.

Source files
------------

// File: rtl/cache_mem_responder.sv
// -----------------------------------------------------------------------------
// cache_mem_responder
//
// Memory-side responder for the set-associative cache controller. Accepts one
// word read or write request at a time over a valid/ready handshake, performs
// it against a local word-addressed RAM after a fixed latency, and returns a
// single response that is held until the controller accepts it.
//
// Ports:
//   clk           clock, all state updates on rising edge
//   rst_n         asynchronous active-low reset
//   i_req_valid   request present
//   o_req_ready   responder can accept a request (IDLE only)
//   i_req_op      0 = read, 1 = write
//   i_req_addr    byte address
//   i_req_wdata   write data, ignored for reads
//   o_rsp_valid   response present (RESP only)
//   i_rsp_ready   controller accepts the response
//   o_rsp_op      echo of the accepted request op
//   o_rsp_data    read data; 0 for writes and errors
//   o_rsp_err     request was out of range or misaligned
// -----------------------------------------------------------------------------
module cache_mem_responder #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 13,
    parameter int READ_LAT   = 4,   // 1..15
    parameter int WRITE_LAT  = 2    // 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_op,
    input  logic [31:0]       i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_op,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // The counter is preloaded with LAT-1 so the BUSY->RESP edge is exactly
    // the LAT-th edge after acceptance.
    localparam logic [3:0] READ_CNT  = 4'(READ_LAT - 1);
    localparam logic [3:0] WRITE_CNT = 4'(WRITE_LAT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic                r_op;
    logic [31:0]         r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_mem [0:(1<<DEPTH_LOG2)-1];

    logic [DEPTH_LOG2-1:0] w_index;
    logic                  w_err;
    logic                  w_accept;
    logic                  w_access;
    logic                  w_mem_we;

    assign w_index  = r_addr[DEPTH_LOG2+1:2];
    assign w_err    = (r_addr[1:0] != 2'b00) || (r_addr[31:DEPTH_LOG2+2] != '0);
    assign w_accept = (r_state == IDLE) && i_req_valid;
    assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);
    // Write enable is derived from the state register, so an async reset
    // during BUSY kills the pending write along with the response.
    assign w_mem_we = w_access && r_op && !w_err;

    assign o_req_ready = (r_state == IDLE);
    assign o_rsp_valid = (r_state == RESP);
    assign o_rsp_op    = r_op;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next-state gets a default before the case so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_req_valid)   w_next_state = BUSY;
            BUSY:    if (r_cnt == 4'd0) w_next_state = RESP;
            RESP:    if (i_rsp_ready)   w_next_state = IDLE;
            default:                    w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 4'd0;
            r_op       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= i_req_op;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_cnt   <= i_req_op ? WRITE_CNT : READ_CNT;
            end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                r_rsp_err  <= w_err;
                r_rsp_data <= (r_op || w_err) ? '0 : r_mem[w_index];
            end else if ((r_state == RESP) && i_rsp_ready) begin
                r_rsp_err  <= 1'b0;
                r_rsp_data <= '0;
            end
        end
    end

    // NOTE: the RAM array has no reset; contents stay undefined until written,
    // which keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_index] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_responder
//
// Directed bench for cache_mem_responder. Instance u_dut uses READ_LAT=4,
// WRITE_LAT=2; instance u_dut_fast uses READ_LAT=1, WRITE_LAT=1 with the
// response side tied ready to check the minimum request spacing.
// -----------------------------------------------------------------------------
module tb_cache_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_op;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_op, rsp_err;
    logic [31:0] rsp_data;

    logic        f_req_valid, f_req_ready, f_req_op;
    logic [31:0] f_req_addr, f_req_wdata;
    logic        f_rsp_valid, f_rsp_ready, f_rsp_op, f_rsp_err;
    logic [31:0] f_rsp_data;

    int n_tests = 0;
    int n_fail  = 0;

    cache_mem_responder #(
        .DATA_W(32), .DEPTH_LOG2(13), .READ_LAT(4), .WRITE_LAT(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_op(rsp_op), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err)
    );

    cache_mem_responder #(
        .DATA_W(32), .DEPTH_LOG2(13), .READ_LAT(1), .WRITE_LAT(1)
    ) u_dut_fast (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(f_req_valid), .o_req_ready(f_req_ready),
        .i_req_op(f_req_op), .i_req_addr(f_req_addr), .i_req_wdata(f_req_wdata),
        .o_rsp_valid(f_rsp_valid), .i_rsp_ready(f_rsp_ready),
        .o_rsp_op(f_rsp_op), .o_rsp_data(f_rsp_data), .o_rsp_err(f_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Caller is #1 after a rising edge with req_ready high. Returns the number
    // of edges after the acceptance edge until rsp_valid is seen.
    task automatic issue(input logic op, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat);
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rsp_valid && lat < 20);
        if (!rsp_valid) check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_valid_clr"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_data_clr"}, rsp_data, 32'd0);
    endtask

    task automatic do_req(input string tag, input logic op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_lat,
                          input logic [31:0] exp_data, input logic exp_err);
        int lat;
        issue(op, addr, wdata, lat);
        check({tag, "_lat"},  lat, exp_lat);
        check({tag, "_op"},   {31'd0, rsp_op}, {31'd0, op});
        check({tag, "_data"}, rsp_data, exp_data);
        check({tag, "_err"},  {31'd0, rsp_err}, {31'd0, exp_err});
        release_rsp(tag);
    endtask

    initial begin
        int lat;
        int seen;
        int acc[$];
        int rsp[$];

        req_valid = 1'b0; req_op = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        f_req_valid = 1'b0; f_req_op = 1'b0; f_req_addr = '0; f_req_wdata = '0;
        f_rsp_ready = 1'b1;

        // Reset state
        #12;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_op",    {31'd0, rsp_op},    32'd0);
        check("rst_rsp_data",  rsp_data,           32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read, index distinctness
        do_req("w64",   1'b1,   64,  111, 2,    0, 1'b0);
        do_req("r64",   1'b0,   64,    0, 4,  111, 1'b0);
        do_req("w1088", 1'b1, 1088,  222, 2,    0, 1'b0);
        do_req("w2112", 1'b1, 2112, 5000, 2,    0, 1'b0);
        do_req("r1088", 1'b0, 1088,    0, 4,  222, 1'b0);
        do_req("r2112", 1'b0, 2112,    0, 4, 5000, 1'b0);
        do_req("r64b",  1'b0,   64,    0, 4,  111, 1'b0);

        // Back-pressure: response held stable for 5 cycles
        issue(1'b0, 2112, 0, lat);
        check("bp_lat", lat, 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_data",  rsp_data, 32'd5000);
            check("bp_ready", {31'd0, req_ready}, 32'd0);
        end
        release_rsp("bp");

        // Errors: misaligned read, out-of-range write must not alias index 0
        do_req("mis66", 1'b0,    66, 0, 4,  0, 1'b1);
        do_req("w0",    1'b1,     0, 55, 2, 0, 1'b0);
        do_req("oor",   1'b1, 32768, 7, 2,  0, 1'b1);
        do_req("r0",    1'b0,     0, 0, 4, 55, 1'b0);

        // Reset mid-operation drops the pending write and its response
        do_req("w128a", 1'b1, 128, 77, 2, 0, 1'b0);
        req_op = 1'b1; req_addr = 128; req_wdata = 9; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_busy", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_op",    {31'd0, rsp_op},    32'd0);
        check("mid_rst_data",  rsp_data,           32'd0);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("mid_no_rsp", seen, 0);
        do_req("r128a", 1'b0, 128, 0, 4, 77, 1'b0);
        do_req("w128",  1'b1, 128, 3, 2, 0, 1'b0);
        do_req("r128",  1'b0, 128, 0, 4, 3, 1'b0);

        // Fast instance: READ_LAT=1, back-to-back reads with rsp_ready high.
        // Observation at index c is #1 after edge c; ready seen there means
        // edge c+1 accepts, rsp_valid seen there means it rose after edge c.
        f_req_op = 1'b0; f_req_addr = 32'd16; f_req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (f_req_ready) acc.push_back(c + 1);
            if (f_rsp_valid) begin
                rsp.push_back(c);
                check("fast_err", {31'd0, f_rsp_err}, 32'd0);
            end
            @(posedge clk); #1;
        end
        f_req_valid = 1'b0;
        check("fast_acc_cnt", {31'd0, acc.size() >= 3}, 32'd1);
        check("fast_rsp_cnt", {31'd0, rsp.size() >= 2}, 32'd1);
        if (acc.size() >= 3 && rsp.size() >= 2) begin
            check("fast_gap0", acc[1] - acc[0], 3);
            check("fast_gap1", acc[2] - acc[1], 3);
            check("fast_lat0", rsp[0] - acc[0], 1);
            check("fast_lat1", rsp[1] - acc[1], 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
